// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ksa_pkg
//  Description : Shared word width and sequencer state encoding.
//  Revision    : 1.0
// ============================================================================
package ksa_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/kogge_stone_adder.sv
`default_nettype none
// ============================================================================
//  Module      : kogge_stone_adder
//  Description : Combinational 16-bit Kogge-Stone adder with carry in/out.
//  Revision    : 1.0
// ============================================================================
module kogge_stone_adder
    import ksa_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              c_in,
    output logic [WORD_W-1:0] sum,
    output logic              c_out
);

    logic [WORD_W-1:0] w_p0;
    logic [WORD_W-1:0] w_g;
    logic [WORD_W-1:0] w_p;
    logic [WORD_W-1:0] w_g_nxt;
    logic [WORD_W-1:0] w_p_nxt;

    // Folding c_in into bit 0's generate makes w_g[i] the carry out of bit i.
    always_comb begin
        w_p0    = a ^ b;
        w_g     = a & b;
        w_g[0]  = (a[0] & b[0]) | (w_p0[0] & c_in);
        w_p     = w_p0;
        w_g_nxt = '0;
        w_p_nxt = '0;
        for (int d = 1; d < WORD_W; d = d * 2) begin
            w_g_nxt = w_g;
            w_p_nxt = w_p;
            for (int i = d; i < WORD_W; i++) begin
                w_g_nxt[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                w_p_nxt[i] = w_p[i] & w_p[i-d];
            end
            w_g = w_g_nxt;
            w_p = w_p_nxt;
        end
    end

    assign sum   = w_p0 ^ {w_g[WORD_W-2:0], c_in};
    assign c_out = w_g[WORD_W-1];

endmodule
`default_nettype wire

// File: rtl/ksa_wide_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ksa_wide_add_ctrl
//  Description : WORDS x 16-bit add/subtract sequenced through one 16-bit
//                Kogge-Stone adder, least-significant word first.
//  Revision    : 1.0
// ============================================================================
module ksa_wide_add_ctrl
    import ksa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic [WORD_W*WORDS-1:0]  a,
    input  logic [WORD_W*WORDS-1:0]  b,
    input  logic                     c_in,
    output logic                     busy,
    output logic                     done,
    output logic [WORD_W*WORDS-1:0]  sum,
    output logic                     c_out,
    output logic                     ovf
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(WORDS - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_op_sub;
    logic [W-1:0]      r_a_lat;
    logic [W-1:0]      r_b_lat;
    logic [WORD_W-1:0] r_sum_words [WORDS];

    logic [WORD_W-1:0] w_a_words [WORDS];
    logic [WORD_W-1:0] w_b_words [WORDS];
    logic [WORD_W-1:0] w_a_word;
    logic [WORD_W-1:0] w_b_eff;
    logic [WORD_W-1:0] w_add_sum;
    logic              w_add_cout;
    logic              w_ovf;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
        assign w_a_words[gi]               = r_a_lat[gi*WORD_W +: WORD_W];
        assign w_b_words[gi]               = r_b_lat[gi*WORD_W +: WORD_W];
        assign sum[gi*WORD_W +: WORD_W]    = r_sum_words[gi];
    end

    assign w_a_word = w_a_words[r_idx];
    assign w_b_eff  = w_b_words[r_idx] ^ {WORD_W{r_op_sub}};
    assign w_ovf    = (w_a_word[WORD_W-1] == w_b_eff[WORD_W-1]) &&
                      (w_add_sum[WORD_W-1] != w_a_word[WORD_W-1]);

    kogge_stone_adder u_adder (
        .a     (w_a_word),
        .b     (w_b_eff),
        .c_in  (r_carry),
        .sum   (w_add_sum),
        .c_out (w_add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_op_sub <= 1'b0;
            r_a_lat  <= '0;
            r_b_lat  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                r_sum_words[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_lat  <= a;
                        r_b_lat  <= b;
                        r_op_sub <= op_sub;
                        // Subtract is a + ~b + 1, so the caller's carry is overridden.
                        r_carry  <= op_sub | c_in;
                        r_idx    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_sum_words[r_idx] <= w_add_sum;
                    r_carry            <= w_add_cout;
                    if (r_idx == c_idx_last) begin
                        c_out   <= w_add_cout;
                        ovf     <= w_ovf;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ksa_wide_add_ctrl.md
# ksa_wide_add_ctrl

Multi-cycle sequencer that performs WORDS×16-bit add or subtract by time-multiplexing one 16-bit Kogge-Stone adder, one word per clock, least-significant word first. The block registers the running carry between words. It sits between a requester using a start/done handshake and the existing 16-bit adder datapath. Its purpose is to provide wide arithmetic without widening the prefix tree.

## Interface
- WORDS, default 4: number of 16-bit words per operand. Legal range 2..16. Total width W = 16*WORDS.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- op_sub  in  1  0 = a+b+c_in; 1 = a−b, computed as a + ~b + 1. c_in is ignored when op_sub=1.
- a  in  W  operand A. Latched on an accepted start.
- b  in  W  operand B. Latched on an accepted start.
- c_in  in  1  carry into word 0 for add. Latched on an accepted start.
- busy  out  1  high while words are being computed.
- done  out  1  one-cycle pulse when the result is complete.
- sum  out  W  result register.
- c_out  out  1  carry out of the top word. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement overflow of the W-bit result.

## Operation
- FSM has two states.
  - IDLE: start=1 at a clock edge latches a, b, op_sub and the effective carry-in (c_in, or 1 for subtract). It also clears idx to 0 and moves to RUN.
  - RUN: each edge does the following for word idx:
    - drives adder with a_lat[idx], b_eff[idx] (b_lat word, inverted if op_sub) and carry_reg;
    - writes the adder sum into sum[16*idx +: 16];
    - loads the adder c_out into carry_reg;
    - increments idx.
  - On the edge that processes idx = WORDS−1: latch c_out and ovf, then return to IDLE.
- ovf = (a_lat[W−1] == b_eff[W−1]) && (sum_word[15] != a_lat[W−1]), evaluated on the final word.
- idx width is $clog2(WORDS). idx never wraps past WORDS−1 because the FSM exits first.
- start while busy is ignored. It is not queued and the in-flight operation is unaffected.
- Operand inputs may change freely after the accepting edge. Only latched copies are used.
- sum updates word by word during RUN. sum, c_out and ovf are valid from the done cycle and hold until the first RUN edge of the next operation.
- The adder instance is combinational. All outputs are registers; there is no combinational path from inputs to outputs.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, state=IDLE, idx=0, carry_reg=0, operand latches=0.
- Accepting edge E0 (start=1 in IDLE): busy=1 after E0.
- Edges E1..E_WORDS process words 0..WORDS−1.
- After E_WORDS: done=1 for exactly one cycle, busy=0, and sum/c_out/ovf are final.
- Latency is WORDS cycles from acceptance to done.
- start=1 at edge E_WORDS+1 is accepted (state is already IDLE), so back-to-back operations run one per WORDS+1 cycles. done deasserts on that same edge.
- done and busy are never high together.
- Asserting rst_n low at any time, including mid-RUN, immediately forces all reset values and abandons the partial result. The first start after rst_n deasserts behaves as from power-up.

## Structure
- Shared package ksa_pkg holds:
  - WORD_W = 16;
  - the state typedef enum {IDLE, RUN}.
- Exactly one sub-module: the existing 16-bit kogge_stone_adder, instantiated once as the datapath. Word selection, b inversion and carry muxing stay in this block.
- The carry register, index counter, operand latches and output registers live in this block.

## Test plan
- Carry ripple: WORDS=4, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, c_in=0, add -> sum=0, c_out=1, ovf=0, done exactly 4 cycles after the accepting edge, busy high for those 4 cycles.
- Subtract borrow: a=0, b=1, op_sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, c_out=0, ovf=0.
- Signed overflow, add: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=64'h8000_0000_0000_0000, ovf=1, c_out=0.
- Signed overflow, subtract: a=64'h8000_0000_0000_0000, b=1, op_sub=1 -> sum=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, c_out=1.
- Busy-ignore and back-to-back:
  - Pulse start with different operands at E2. It is ignored and the first result is unchanged.
  - Assert start at E5 with a=3, b=4, c_in=1. It is accepted, giving done at E9 with sum=8.
  - Randomised sweep of 1000 operations against a W-bit reference model.
- Reset mid-op:
  - Drop rst_n after E2 of an operation. All outputs go to 0 immediately and no done pulse appears.
  - After release, a=5, b=6 -> sum=11, done 4 cycles after acceptance.
